// File: rtl/core_sequencer.sv
// Drives the core's instruction bus through n_kij kernel iterations:
// weight load, activation execute, and OFIFO drain into pmem.
module core_sequencer #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int addr_width = 11,
  parameter int flush_cyc  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              n_kij,
  input  logic [addr_width-1:0]   n_act,
  input  logic [addr_width-1:0]   w_base,
  input  logic [addr_width-1:0]   x_base,
  input  logic [addr_width-1:0]   p_base,
  input  logic                    ofifo_valid,
  output logic [2*addr_width+11:0] inst,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = addr_width;
  localparam int IW = 2 * addr_width + 12;

  // Phase counter must span the longest phase: n_act+1 fetch cycles or any fixed length.
  localparam int M1    = (col > row) ? col : row;
  localparam int M2    = (M1 > flush_cyc) ? M1 : flush_cyc;
  localparam int CNT_W = ((M2 > (1 << AW)) ? $clog2(M2) : AW) + 1;

  localparam logic [CNT_W-1:0] COL_C      = CNT_W'(col);
  localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(flush_cyc - 1);
  localparam logic [AW-1:0]    COL_A      = AW'(col);

  // Low control field: [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load
  localparam logic [6:0] CTL_NONE  = 7'b000_0000;
  localparam logic [6:0] CTL_L0_WR = 7'b000_0100;
  localparam logic [6:0] CTL_LOAD  = 7'b000_1001;
  localparam logic [6:0] CTL_EXEC  = 7'b000_1010;
  localparam logic [6:0] CTL_OFIFO = 7'b100_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_FETCH, S_W_LOAD, S_FLUSH, S_X_FETCH, S_X_EXEC,
    S_D_WAIT, S_D_RD, S_D_WR, S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       kij;
  logic [3:0]       n_kij_q;
  logic [AW-1:0]    n_act_q, x_base_q, p_base_q, w_ptr;

  logic [CNT_W-1:0] cnt_inc, act_n, act_last;
  logic [3:0]       kij_inc;

  assign cnt_inc  = cnt + 1'b1;
  assign act_n    = CNT_W'(n_act_q);
  assign act_last = act_n - 1'b1;
  assign kij_inc  = kij + 4'd1;

  function automatic logic [IW-1:0] mk_inst(
    input logic acc, input logic cen_p, input logic wen_p, input logic [AW-1:0] a_p,
    input logic cen_x, input logic [AW-1:0] a_x, input logic [6:0] ctl);
    return {acc, cen_p, wen_p, a_p, cen_x, 1'b1, a_x, ctl};
  endfunction

  function automatic logic [IW-1:0] ctl_inst(input logic [6:0] ctl);
    return mk_inst(1'b0, 1'b1, 1'b1, '0, 1'b1, '0, ctl);
  endfunction

  // xmem reads run one cycle ahead of the matching l0_wr.
  function automatic logic [IW-1:0] fetch_inst(input logic rd, input logic [AW-1:0] a,
                                               input logic wr);
    return mk_inst(1'b0, 1'b1, 1'b1, '0, ~rd, rd ? a : '0, wr ? CTL_L0_WR : CTL_NONE);
  endfunction

  function automatic logic [IW-1:0] pmem_inst(input logic acc, input logic wen,
                                              input logic [AW-1:0] a, input logic [6:0] ctl);
    return mk_inst(acc, 1'b0, wen, a, 1'b1, '0, ctl);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      kij   <= '0;
      inst  <= ctl_inst(CTL_NONE);
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_kij_q  <= n_kij;
            n_act_q  <= n_act;
            x_base_q <= x_base;
            p_base_q <= p_base;
            w_ptr    <= w_base;
            kij      <= '0;
            cnt      <= '0;
            if (n_kij == 4'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_W_FETCH;
              busy  <= 1'b1;
              inst  <= fetch_inst(1'b1, w_base, 1'b0);
            end
          end
        end
        S_W_FETCH: begin
          if (cnt == COL_C) begin
            state <= S_W_LOAD;
            cnt   <= '0;
            inst  <= ctl_inst(CTL_LOAD);
          end else begin
            cnt  <= cnt_inc;
            inst <= fetch_inst(cnt_inc < COL_C, w_ptr + cnt_inc[AW-1:0], 1'b1);
          end
        end
        S_W_LOAD: begin
          if (cnt == COL_LAST) begin
            state <= S_FLUSH;
            cnt   <= '0;
            inst  <= ctl_inst(CTL_NONE);
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state <= S_X_FETCH;
            cnt   <= '0;
            inst  <= fetch_inst(1'b1, x_base_q, 1'b0);
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_X_FETCH: begin
          if (cnt == act_n) begin
            state <= S_X_EXEC;
            cnt   <= '0;
            inst  <= ctl_inst(CTL_EXEC);
          end else begin
            cnt  <= cnt_inc;
            inst <= fetch_inst(cnt_inc < act_n, x_base_q + cnt_inc[AW-1:0], 1'b1);
          end
        end
        S_X_EXEC: begin
          if (cnt == act_last) begin
            cnt <= '0;
            if (ofifo_valid) begin
              state <= S_D_RD;
              inst  <= pmem_inst(1'b0, 1'b1, p_base_q, CTL_OFIFO);
            end else begin
              state <= S_D_WAIT;
              inst  <= ctl_inst(CTL_NONE);
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_D_WAIT: begin
          if (ofifo_valid) begin
            state <= S_D_RD;
            inst  <= pmem_inst(1'b0, 1'b1, p_base_q + cnt[AW-1:0], CTL_OFIFO);
          end
        end
        S_D_RD: begin
          state <= S_D_WR;
          inst  <= pmem_inst(kij != 4'd0, 1'b0, p_base_q + cnt[AW-1:0], CTL_NONE);
        end
        S_D_WR: begin
          if (cnt == act_last) begin
            cnt <= '0;
            if (kij_inc == n_kij_q) begin
              state <= S_DONE;
              kij   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              inst  <= ctl_inst(CTL_NONE);
            end else begin
              state <= S_W_FETCH;
              kij   <= kij_inc;
              w_ptr <= w_ptr + COL_A;
              inst  <= fetch_inst(1'b1, w_ptr + COL_A, 1'b0);
            end
          end else begin
            cnt <= cnt_inc;
            if (ofifo_valid) begin
              state <= S_D_RD;
              inst  <= pmem_inst(1'b0, 1'b1, p_base_q + cnt_inc[AW-1:0], CTL_OFIFO);
            end else begin
              state <= S_D_WAIT;
              inst  <= ctl_inst(CTL_NONE);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          inst  <= ctl_inst(CTL_NONE);
        end
        default: begin
          state <= S_IDLE;
          inst  <= ctl_inst(CTL_NONE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: captures the inst bus per cycle and
// checks addresses, phase timing, drain ordering and done/busy behaviour.
module tb_core_sequencer;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam logic [33:0] EXEC_W = 34'h1_800C_000A;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [3:0]  n_kij;
  logic [10:0] n_act, w_base, x_base, p_base;
  logic [33:0] inst;
  logic        busy, done;

  int checks = 0;
  int passed = 0;

  logic [33:0] trace[$];
  bit          busyq[$];
  logic [10:0] xa[$], pwa[$], pra[$];
  logic        pwacc[$];
  int          n_l0wr, n_load, n_exec;
  int          didx, nd, bad;

  always #5 clk = ~clk;

  core_sequencer #(.row(8), .col(8), .addr_width(11), .flush_cyc(16)) dut (
    .clk(clk), .reset(reset), .start(start), .n_kij(n_kij), .n_act(n_act),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] k, input logic [10:0] na, input logic [10:0] wb,
                             input logic [10:0] xb, input logic [10:0] pb);
    n_kij = k; n_act = na; w_base = wb; x_base = xb; p_base = pb;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Records one inst word per cycle until a few cycles past the first done.
  task automatic run(input int budget, input int stall_vec, input int restart_at,
                     output int d_idx, output int n_done);
    int rem = 0;
    bit stalled = 1'b0;
    trace.delete(); busyq.delete();
    d_idx = -1; n_done = 0;
    for (int c = 0; c < budget; c++) begin
      trace.push_back(inst);
      busyq.push_back(busy);
      if (done === 1'b1) begin
        n_done++;
        if (d_idx < 0) d_idx = c;
      end
      if (d_idx >= 0 && c >= d_idx + 4) break;
      start = (c == restart_at);
      if (rem > 0) begin
        rem--;
        if (rem == 0) ofifo_valid = 1'b1;
      end else if (stall_vec > 0 && !stalled && inst[32] == 1'b0 && inst[31] == 1'b0 &&
                   inst[30:20] == p_base + 11'(stall_vec - 1)) begin
        ofifo_valid = 1'b0;
        rem = 5;
        stalled = 1'b1;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic collect();
    xa.delete(); pwa.delete(); pra.delete(); pwacc.delete();
    n_l0wr = 0; n_load = 0; n_exec = 0;
    foreach (trace[k]) begin
      if (!trace[k][19]) xa.push_back(trace[k][17:7]);
      if (!trace[k][32] && !trace[k][31]) begin
        pwa.push_back(trace[k][30:20]);
        pwacc.push_back(trace[k][33]);
      end
      if (!trace[k][32] && trace[k][31]) pra.push_back(trace[k][30:20]);
      n_l0wr += int'(trace[k][2]);
      n_load += int'(trace[k][0]);
      n_exec += int'(trace[k][1]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
    n_kij = '0; n_act = 11'd1; w_base = '0; x_base = '0; p_base = '0;
    repeat (3) step();
    check("rst_inst", inst, IDLE_W);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    step();
    check("rst_idle_hold", inst, IDLE_W);

    // T1: reset held 3 cycles in the middle of X_EXEC
    pulse_start(4'd1, 11'd4, 11'h010, 11'h040, 11'h100);
    repeat (39) step();
    check("t1_in_exec", inst, EXEC_W);
    check("t1_busy_run", busy, 1);
    reset = 1'b1;
    step();
    check("t1_rst_inst", inst, IDLE_W);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_done", done, 0);
    repeat (2) step();
    reset = 1'b0;
    nd = 0;
    repeat (4) begin
      step();
      if (done === 1'b1) nd++;
    end
    check("t1_no_done", nd, 0);
    check("t1_idle_after", inst, IDLE_W);

    // T2: single kij, four activation vectors
    pulse_start(4'd1, 11'd4, 11'h010, 11'h040, 11'h100);
    run(200, 0, -1, didx, nd);
    collect();
    check("t2_done_idx", didx, 50);
    check("t2_done_cnt", nd, 1);
    check("t2_first_fetch", trace[0], 34'h1_8004_0800);
    check("t2_last_l0wr", trace[8], 34'h1_800C_0004);
    check("t2_first_load", trace[9], 34'h1_800C_0009);
    check("t2_first_rd", trace[42], 34'h0_900C_0040);
    check("t2_first_wr", trace[43], 34'h0_100C_0000);
    check("t2_busy_start", busyq[0], 1);
    check("t2_busy_done", busyq[50], 0);
    check("t2_xa_size", xa.size(), 12);
    for (int j = 0; j < 8; j++) check($sformatf("t2_wa%0d", j), xa[j], 11'h010 + 11'(j));
    for (int i = 0; i < 4; i++) check($sformatf("t2_xa%0d", i), xa[8+i], 11'h040 + 11'(i));
    check("t2_pw_size", pwa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_pw%0d", i), pwa[i], 11'h100 + 11'(i));
      check($sformatf("t2_acc%0d", i), pwacc[i], 0);
    end
    check("t2_l0wr", n_l0wr, 12);
    check("t2_load", n_load, 8);
    check("t2_exec", n_exec, 4);

    // T3: three kernel iterations, weights stride by col
    pulse_start(4'd3, 11'd2, 11'h000, 11'h020, 11'h200);
    run(400, 0, -1, didx, nd);
    collect();
    check("t3_done_idx", didx, 126);
    check("t3_done_cnt", nd, 1);
    check("t3_xa_size", xa.size(), 30);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++)
        check($sformatf("t3_k%0d_wa%0d", k, j), xa[k*10+j], 11'(k*8 + j));
      for (int i = 0; i < 2; i++)
        check($sformatf("t3_k%0d_xa%0d", k, i), xa[k*10+8+i], 11'h020 + 11'(i));
    end
    check("t3_pw_size", pwa.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_pw%0d", i), pwa[i], 11'h200 + 11'(i % 2));
      check($sformatf("t3_acc%0d", i), pwacc[i], (i >= 2) ? 1 : 0);
    end

    // T4: ofifo_valid low for 5 cycles ahead of vector 2
    pulse_start(4'd1, 11'd4, 11'h010, 11'h040, 11'h100);
    run(200, 2, -1, didx, nd);
    collect();
    check("t4_done_idx", didx, 55);
    check("t4_done_cnt", nd, 1);
    check("t4_wr1", trace[45], 34'h0_101C_0000);
    bad = 0;
    for (int k = 46; k <= 50; k++) if (trace[k] !== IDLE_W) bad++;
    check("t4_stall_idle", bad, 0);
    check("t4_rd2", trace[51], 34'h0_902C_0040);
    check("t4_wr2", trace[52], 34'h0_102C_0000);
    check("t4_rd_size", pra.size(), 4);
    bad = 0;
    for (int k = 0; k + 1 < trace.size(); k++)
      if (!trace[k][32] && trace[k][31] &&
          !(trace[k+1][32] == 1'b0 && trace[k+1][31] == 1'b0 &&
            trace[k+1][30:20] == trace[k][30:20])) bad++;
    check("t4_rd_then_wr", bad, 0);

    // T5: n_kij=0 completes immediately; start during a run is ignored
    pulse_start(4'd0, 11'd1, 11'h000, 11'h000, 11'h000);
    check("t5_zero_done", done, 1);
    check("t5_zero_busy", busy, 0);
    check("t5_zero_inst", inst, IDLE_W);
    step();
    check("t5_zero_done_end", done, 0);
    check("t5_zero_inst_end", inst, IDLE_W);
    pulse_start(4'd1, 11'd1, 11'h000, 11'h030, 11'h300);
    n_kij = 4'd2; n_act = 11'd3;
    run(200, 0, 10, didx, nd);
    collect();
    check("t5_done_idx", didx, 38);
    check("t5_done_cnt", nd, 1);
    check("t5_pw_size", pwa.size(), 1);
    check("t5_pw0", pwa[0], 11'h300);
    check("t5_tail_idle", trace[trace.size()-1], IDLE_W);
    check("t5_tail_busy", busyq[busyq.size()-1], 0);

    // T6: activation and psum addresses wrap at 2^addr_width
    pulse_start(4'd1, 11'd4, 11'h000, 11'h7FE, 11'h7FF);
    run(200, 0, -1, didx, nd);
    collect();
    check("t6_done_idx", didx, 50);
    check("t6_xa8", xa[8], 11'h7FE);
    check("t6_xa9", xa[9], 11'h7FF);
    check("t6_xa10", xa[10], 11'h000);
    check("t6_xa11", xa[11], 11'h001);
    check("t6_pw0", pwa[0], 11'h7FF);
    check("t6_pw1", pwa[1], 11'h000);
    check("t6_pw3", pwa[3], 11'h002);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
